// File: rtl/estacao_reserva.sv
// estacao_reserva: two-entry Tomasulo reservation station with CDB snooping and oldest-first dispatch.
// Optional same-cycle CDB-to-dispatch bypass is enabled by defining ESTACAO_BYPASS_CDB_EN.
//
// state      | meaning
// LIVRE      | entry free, may accept an issue
// ESPERA     | occupied, at least one operand still waiting on a producer tag
// PRONTA     | both operands resolved, waiting to be dispatched
// EXECUTANDO | dispatched, held until its own tag appears on the CDB
module estacao_reserva #(
  parameter logic [15:0] Vj_Vk_sem_valor = 16'b1111_1111_1111_0000,
  parameter logic [2:0]  Qj_Qk_sem_valor = 3'b000,
  parameter logic [2:0]  TAG_BASE        = 3'b001
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic [2:0]  issue_op,
  input  logic [15:0] issue_Vj,
  input  logic [15:0] issue_Vk,
  input  logic [2:0]  issue_Qj,
  input  logic [2:0]  issue_Qk,
  output logic [2:0]  issue_tag,
  input  logic        CDB_valid,
  input  logic [2:0]  Qi_CDB,
  input  logic [15:0] Qi_CDB_data,
  output logic        disp_valid,
  input  logic        disp_ready,
  output logic [2:0]  disp_op,
  output logic [15:0] disp_Vj,
  output logic [15:0] disp_Vk,
  output logic [2:0]  disp_tag
);

  typedef enum logic [1:0] {LIVRE, ESPERA, PRONTA, EXECUTANDO} estado_t;

  estado_t     estado_q [2];
  estado_t     estado_d [2];
  logic [2:0]  op_q [2];
  logic [2:0]  op_d [2];
  logic [15:0] vj_q [2];
  logic [15:0] vj_d [2];
  logic [15:0] vk_q [2];
  logic [15:0] vk_d [2];
  logic [2:0]  qj_q [2];
  logic [2:0]  qj_d [2];
  logic [2:0]  qk_q [2];
  logic [2:0]  qk_d [2];
  logic [1:0]  jovem_q;  // 1: entry was issued after the other occupied entry
  logic [1:0]  jovem_d;

  logic [2:0]  tag_ent [2];
  logic [1:0]  livre, pronta, libera, snoop_j, snoop_k, bypass, cand;
  logic        cdb_hit, issue_fire, issue_idx, disp_fire, sel, sel_byp;

  assign tag_ent[0] = TAG_BASE;
  assign tag_ent[1] = TAG_BASE + 3'd1;

  always_comb begin
    cdb_hit = CDB_valid && (Qi_CDB != Qj_Qk_sem_valor);
    livre   = '0;
    pronta  = '0;
    libera  = '0;
    snoop_j = '0;
    snoop_k = '0;
    bypass  = '0;
    for (int i = 0; i < 2; i++) begin
      livre[i]   = (estado_q[i] == LIVRE);
      pronta[i]  = (estado_q[i] == PRONTA);
      libera[i]  = (estado_q[i] == EXECUTANDO) && cdb_hit && (Qi_CDB == tag_ent[i]);
      snoop_j[i] = (estado_q[i] == ESPERA) && cdb_hit && (qj_q[i] == Qi_CDB);
      snoop_k[i] = (estado_q[i] == ESPERA) && cdb_hit && (qk_q[i] == Qi_CDB);
`ifdef ESTACAO_BYPASS_CDB_EN
      bypass[i]  = (estado_q[i] == ESPERA) && cdb_hit &&
                   ((qj_q[i] == Qj_Qk_sem_valor) || snoop_j[i]) &&
                   ((qk_q[i] == Qj_Qk_sem_valor) || snoop_k[i]);
`endif
    end
  end

  always_comb begin
    issue_ready = |livre;
    issue_idx   = ~livre[0];
    issue_tag   = tag_ent[issue_idx];
    issue_fire  = issue_valid && issue_ready;

    // registered PRONTA entries always win over bypass candidates
    cand       = (|pronta) ? pronta : bypass;
    sel_byp    = ~(|pronta) && (|bypass);
    sel        = cand[1] && (!cand[0] || jovem_q[0]);
    disp_valid = |cand;
    disp_fire  = disp_valid && disp_ready;

    disp_op  = op_q[sel];
    disp_tag = tag_ent[sel];
    disp_Vj  = vj_q[sel];
    disp_Vk  = vk_q[sel];
    if (sel_byp && (qj_q[sel] != Qj_Qk_sem_valor)) disp_Vj = Qi_CDB_data;
    if (sel_byp && (qk_q[sel] != Qj_Qk_sem_valor)) disp_Vk = Qi_CDB_data;
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      estado_d[i] = estado_q[i];
      op_d[i]     = op_q[i];
      vj_d[i]     = vj_q[i];
      vk_d[i]     = vk_q[i];
      qj_d[i]     = qj_q[i];
      qk_d[i]     = qk_q[i];

      unique case (estado_q[i])
        LIVRE: begin
          if (issue_fire && (issue_idx == 1'(i))) begin
            op_d[i] = issue_op;
            if (issue_Qj == Qj_Qk_sem_valor) begin
              vj_d[i] = issue_Vj;
              qj_d[i] = Qj_Qk_sem_valor;
            end else if (cdb_hit && (issue_Qj == Qi_CDB)) begin
              vj_d[i] = Qi_CDB_data;
              qj_d[i] = Qj_Qk_sem_valor;
            end else begin
              vj_d[i] = Vj_Vk_sem_valor;
              qj_d[i] = issue_Qj;
            end
            if (issue_Qk == Qj_Qk_sem_valor) begin
              vk_d[i] = issue_Vk;
              qk_d[i] = Qj_Qk_sem_valor;
            end else if (cdb_hit && (issue_Qk == Qi_CDB)) begin
              vk_d[i] = Qi_CDB_data;
              qk_d[i] = Qj_Qk_sem_valor;
            end else begin
              vk_d[i] = Vj_Vk_sem_valor;
              qk_d[i] = issue_Qk;
            end
            estado_d[i] = ((qj_d[i] == Qj_Qk_sem_valor) && (qk_d[i] == Qj_Qk_sem_valor))
                          ? PRONTA : ESPERA;
          end
        end
        ESPERA: begin
          if (snoop_j[i]) begin
            vj_d[i] = Qi_CDB_data;
            qj_d[i] = Qj_Qk_sem_valor;
          end
          if (snoop_k[i]) begin
            vk_d[i] = Qi_CDB_data;
            qk_d[i] = Qj_Qk_sem_valor;
          end
          if (disp_fire && (sel == 1'(i)))
            estado_d[i] = EXECUTANDO;
          else if ((qj_d[i] == Qj_Qk_sem_valor) && (qk_d[i] == Qj_Qk_sem_valor))
            estado_d[i] = PRONTA;
        end
        PRONTA: begin
          if (disp_fire && (sel == 1'(i))) estado_d[i] = EXECUTANDO;
        end
        EXECUTANDO: begin
          if (libera[i]) begin
            estado_d[i] = LIVRE;
            op_d[i]     = '0;
            vj_d[i]     = Vj_Vk_sem_valor;
            vk_d[i]     = Vj_Vk_sem_valor;
            qj_d[i]     = Qj_Qk_sem_valor;
            qk_d[i]     = Qj_Qk_sem_valor;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    jovem_d = jovem_q & ~libera;
    if (issue_fire) begin
      // younger only if the other entry stays occupied past this edge
      jovem_d[issue_idx]  = !livre[~issue_idx] && !libera[~issue_idx];
      jovem_d[~issue_idx] = 1'b0;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < 2; i++) begin
        estado_q[i] <= LIVRE;
        op_q[i]     <= '0;
        vj_q[i]     <= Vj_Vk_sem_valor;
        vk_q[i]     <= Vj_Vk_sem_valor;
        qj_q[i]     <= Qj_Qk_sem_valor;
        qk_q[i]     <= Qj_Qk_sem_valor;
      end
      jovem_q <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        estado_q[i] <= estado_d[i];
        op_q[i]     <= op_d[i];
        vj_q[i]     <= vj_d[i];
        vk_q[i]     <= vk_d[i];
        qj_q[i]     <= qj_d[i];
        qk_q[i]     <= qk_d[i];
      end
      jovem_q <= jovem_d;
    end
  end

endmodule

// File: tb/tb_estacao_reserva.sv
// Bench for estacao_reserva: directed scenarios with literal expectations, then randomized
// traffic checked every cycle against an issue-order/operand-availability model.
module tb_estacao_reserva;

  localparam logic [15:0] SENT = 16'hFFF0;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        issue_valid, issue_ready;
  logic [2:0]  issue_op, issue_Qj, issue_Qk, issue_tag;
  logic [15:0] issue_Vj, issue_Vk;
  logic        CDB_valid;
  logic [2:0]  Qi_CDB;
  logic [15:0] Qi_CDB_data;
  logic        disp_valid, disp_ready;
  logic [2:0]  disp_op, disp_tag;
  logic [15:0] disp_Vj, disp_Vk;

  always #5 Clock = ~Clock;

  estacao_reserva dut (
    .Clock(Clock), .Reset(Reset),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
    .issue_Vj(issue_Vj), .issue_Vk(issue_Vk), .issue_Qj(issue_Qj), .issue_Qk(issue_Qk),
    .issue_tag(issue_tag),
    .CDB_valid(CDB_valid), .Qi_CDB(Qi_CDB), .Qi_CDB_data(Qi_CDB_data),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
    .disp_Vj(disp_Vj), .disp_Vk(disp_Vk), .disp_tag(disp_tag)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // model: each slot remembers whether it holds an instruction, whether it has been sent to
  // the unit, which producer tags it still needs, and when it was issued (for oldest-first)
  logic        m_occ [2];
  logic        m_exec [2];
  logic [2:0]  m_op [2];
  logic [2:0]  m_qj [2];
  logic [2:0]  m_qk [2];
  logic [15:0] m_vj [2];
  logic [15:0] m_vk [2];
  int          m_seq [2];
  int          seq_ctr;

  logic        e_ready, e_valid, e_byp;
  logic [2:0]  e_itag, e_tag;
  int          e_sel;
  logic [15:0] e_vj, e_vk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic on_cdb(input logic [2:0] q);
    return CDB_valid && (Qi_CDB != 3'd0) && (q == Qi_CDB);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_occ[i] = 0; m_exec[i] = 0; m_op[i] = 0;
      m_qj[i] = 0; m_qk[i] = 0; m_vj[i] = SENT; m_vk[i] = SENT; m_seq[i] = 0;
    end
    seq_ctr = 0;
  endtask

  task automatic model_outputs();
    int best;
    best    = -1;
    e_ready = !m_occ[0] || !m_occ[1];
    e_itag  = !m_occ[0] ? 3'd1 : 3'd2;
    for (int i = 0; i < 2; i++)
      if (m_occ[i] && !m_exec[i] && m_qj[i] == 0 && m_qk[i] == 0 &&
          (best < 0 || m_seq[i] < m_seq[best])) best = i;
    e_byp = 0;
`ifdef ESTACAO_BYPASS_CDB_EN
    if (best < 0) begin
      for (int i = 0; i < 2; i++)
        if (m_occ[i] && !m_exec[i] && (m_qj[i] == 0 || on_cdb(m_qj[i])) &&
            (m_qk[i] == 0 || on_cdb(m_qk[i])) && (best < 0 || m_seq[i] < m_seq[best])) best = i;
      e_byp = (best >= 0);
    end
`endif
    e_valid = (best >= 0);
    e_sel   = (best < 0) ? 0 : best;
    e_tag   = (e_sel == 0) ? 3'd1 : 3'd2;
    e_vj    = (e_byp && m_qj[e_sel] != 0) ? Qi_CDB_data : m_vj[e_sel];
    e_vk    = (e_byp && m_qk[e_sel] != 0) ? Qi_CDB_data : m_vk[e_sel];
  endtask

  task automatic model_step();
    logic rel [2];
    int   k;
    if (Reset) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 2; i++) rel[i] = m_occ[i] && m_exec[i] && on_cdb(3'(i + 1));
    for (int i = 0; i < 2; i++)
      if (m_occ[i] && !m_exec[i]) begin
        if (m_qj[i] != 0 && on_cdb(m_qj[i])) begin m_vj[i] = Qi_CDB_data; m_qj[i] = 0; end
        if (m_qk[i] != 0 && on_cdb(m_qk[i])) begin m_vk[i] = Qi_CDB_data; m_qk[i] = 0; end
      end
    if (e_valid && disp_ready) m_exec[e_sel] = 1;
    if (issue_valid && e_ready) begin
      k = m_occ[0] ? 1 : 0;
      m_occ[k] = 1; m_exec[k] = 0; m_op[k] = issue_op; m_seq[k] = seq_ctr++;
      if (issue_Qj == 0)           begin m_vj[k] = issue_Vj;    m_qj[k] = 0; end
      else if (on_cdb(issue_Qj))   begin m_vj[k] = Qi_CDB_data; m_qj[k] = 0; end
      else                         begin m_vj[k] = SENT;        m_qj[k] = issue_Qj; end
      if (issue_Qk == 0)           begin m_vk[k] = issue_Vk;    m_qk[k] = 0; end
      else if (on_cdb(issue_Qk))   begin m_vk[k] = Qi_CDB_data; m_qk[k] = 0; end
      else                         begin m_vk[k] = SENT;        m_qk[k] = issue_Qk; end
    end
    for (int i = 0; i < 2; i++)
      if (rel[i]) begin
        m_occ[i] = 0; m_exec[i] = 0; m_qj[i] = 0; m_qk[i] = 0; m_vj[i] = SENT; m_vk[i] = SENT;
      end
  endtask

  // apply inputs for one cycle and compare against the model
  task automatic drive(input logic iv, input logic [2:0] op, input logic [15:0] vj,
                       input logic [15:0] vk, input logic [2:0] qj, input logic [2:0] qk,
                       input logic cv, input logic [2:0] ct, input logic [15:0] cd,
                       input logic dr, input logic rst);
    @(negedge Clock);
    issue_valid = iv; issue_op = op; issue_Vj = vj; issue_Vk = vk;
    issue_Qj = qj; issue_Qk = qk; CDB_valid = cv; Qi_CDB = ct; Qi_CDB_data = cd;
    disp_ready = dr; Reset = rst;
    #1;
    model_outputs();
    chk("issue_ready", 32'(issue_ready), 32'(e_ready));
    if (e_ready) chk("issue_tag", 32'(issue_tag), 32'(e_itag));
    chk("disp_valid", 32'(disp_valid), 32'(e_valid));
    if (e_valid) begin
      chk("disp_op", 32'(disp_op), 32'(m_op[e_sel]));
      chk("disp_tag", 32'(disp_tag), 32'(e_tag));
      chk("disp_Vj", 32'(disp_Vj), 32'(e_vj));
      chk("disp_Vk", 32'(disp_Vk), 32'(e_vk));
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    model_step();
  endtask

  task automatic idle(input logic dr);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, dr, 0);
  endtask

  task automatic bcast(input logic [2:0] t, input logic [15:0] d, input logic dr);
    drive(0, 0, 0, 0, 0, 0, 1, t, d, dr, 0);
  endtask

  task automatic check_reset_vals();
    chk("rst issue_ready", 32'(issue_ready), 32'd1);
    chk("rst issue_tag", 32'(issue_tag), 32'd1);
    chk("rst disp_valid", 32'(disp_valid), 32'd0);
    chk("rst disp_op", 32'(disp_op), 32'd0);
    chk("rst disp_Vj", 32'(disp_Vj), 32'(SENT));
    chk("rst disp_Vk", 32'(disp_Vk), 32'(SENT));
    chk("rst disp_tag", 32'(disp_tag), 32'd1);
  endtask

  initial begin
    Reset = 1; issue_valid = 0; issue_op = 0; issue_Vj = 0; issue_Vk = 0;
    issue_Qj = 0; issue_Qk = 0; CDB_valid = 0; Qi_CDB = 0; Qi_CDB_data = 0; disp_ready = 0;
    model_reset();
    repeat (2) @(posedge Clock);

    idle(0); check_reset_vals(); tick();

    // operands ready at issue: dispatchable next cycle
    drive(1, 3'd3, 16'd5, 16'd7, 0, 0, 0, 0, 0, 1, 0);
    chk("t1 issue_tag", 32'(issue_tag), 32'd1);
    tick();
    idle(1);
    chk("t1 disp_valid", 32'(disp_valid), 32'd1);
    chk("t1 disp_Vj", 32'(disp_Vj), 32'd5);
    chk("t1 disp_Vk", 32'(disp_Vk), 32'd7);
    chk("t1 disp_tag", 32'(disp_tag), 32'd1);
    chk("t1 issue_ready", 32'(issue_ready), 32'd1);
    tick();
    bcast(3'd1, 16'h0BAD, 0); tick();

    // one operand pending, arrives on the CDB later
    drive(1, 3'd2, 16'h1111, 16'd9, 3'd4, 0, 0, 0, 0, 1, 0); tick();
    idle(1); tick();
    idle(1); tick();
    bcast(3'd4, 16'h0020, 1);
`ifdef ESTACAO_BYPASS_CDB_EN
    chk("t2 byp disp_valid", 32'(disp_valid), 32'd1);
    chk("t2 byp disp_Vj", 32'(disp_Vj), 32'h0020);
    chk("t2 byp disp_Vk", 32'(disp_Vk), 32'd9);
    tick();
`else
    chk("t2 disp_valid early", 32'(disp_valid), 32'd0);
    tick();
    idle(1);
    chk("t2 disp_valid", 32'(disp_valid), 32'd1);
    chk("t2 disp_Vj", 32'(disp_Vj), 32'h0020);
    chk("t2 disp_Vk", 32'(disp_Vk), 32'd9);
    tick();
`endif
    bcast(3'd1, 16'h0, 0); tick();

    // fill both, dispatch entry 0, then release it with its own tag
    drive(1, 3'd1, 16'h11, 16'h22, 0, 0, 0, 0, 0, 0, 0);
    chk("t3 issue_tag0", 32'(issue_tag), 32'd1);
    tick();
    drive(1, 3'd4, 16'h0, 16'h33, 3'd6, 0, 0, 0, 0, 1, 0);
    chk("t3 issue_tag1", 32'(issue_tag), 32'd2);
    chk("t3 disp_valid", 32'(disp_valid), 32'd1);
    tick();
    idle(0);
    chk("t3 full", 32'(issue_ready), 32'd0);
    tick();
    bcast(3'd1, 16'hDEAD, 0);
    chk("t3 not yet free", 32'(issue_ready), 32'd0);
    tick();
    idle(0);
    chk("t3 freed ready", 32'(issue_ready), 32'd1);
    chk("t3 freed tag", 32'(issue_tag), 32'd1);
    tick();

    // entry 1 is older; both resolve together -> entry 1 goes first
    drive(1, 3'd5, 16'h0, 16'h44, 3'd6, 0, 0, 0, 0, 0, 0); tick();
    bcast(3'd6, 16'hABCD, 0); tick();
    idle(1);
    chk("t5 disp_valid", 32'(disp_valid), 32'd1);
    chk("t5 older first", 32'(disp_tag), 32'd2);
    chk("t5 disp_Vj", 32'(disp_Vj), 32'hABCD);
    tick();
    idle(1);
    chk("t5 second tag", 32'(disp_tag), 32'd1);
    chk("t5 second Vk", 32'(disp_Vk), 32'h44);
    tick();
    bcast(3'd2, 16'h0, 0); tick();
    bcast(3'd1, 16'h0, 0); tick();

    // both operands captured from the broadcast in the issue cycle
    drive(1, 3'd6, 16'h0, 16'h0, 3'd5, 3'd5, 1, 3'd5, 16'h1234, 1, 0);
    chk("t4 issue_tag", 32'(issue_tag), 32'd1);
    tick();
    idle(1);
    chk("t4 disp_valid", 32'(disp_valid), 32'd1);
    chk("t4 disp_Vj", 32'(disp_Vj), 32'h1234);
    chk("t4 disp_Vk", 32'(disp_Vk), 32'h1234);
    chk("t4 disp_op", 32'(disp_op), 32'd6);
    tick();
    bcast(3'd1, 16'h0, 0); tick();

    // reset while one entry executes and the other waits
    drive(1, 3'd7, 16'h55, 16'h66, 0, 0, 0, 0, 0, 1, 0); tick();
    drive(1, 3'd2, 16'h0, 16'h1, 3'd7, 0, 0, 0, 0, 1, 0); tick();
    idle(0);
    chk("t6 full before reset", 32'(issue_ready), 32'd0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); tick();
    idle(0); check_reset_vals(); tick();
    bcast(3'd1, 16'h7777, 1); tick();
    bcast(3'd7, 16'h8888, 1); tick();
    idle(1);
    chk("t6 stale disp_valid", 32'(disp_valid), 32'd0);
    chk("t6 stale issue_ready", 32'(issue_ready), 32'd1);
    tick();

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            16'($urandom), 16'($urandom),
            ($urandom_range(0, 1) != 0) ? 3'd0 : 3'($urandom_range(1, 7)),
            ($urandom_range(0, 1) != 0) ? 3'd0 : 3'($urandom_range(1, 7)),
            1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
            ($urandom_range(0, 9) < 7), ($urandom_range(0, 99) == 0));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/estacao_reserva.md
# estacao_reserva

Two-entry reservation station for one functional unit (UF) in the Tomasulo pipeline. It sits directly upstream of the UF operand selector. It accepts issued instructions with operands given either as values (Vj/Vk) or as producer tags (Qj/Qk), and snoops the CDB to fill pending operands. It dispatches the oldest fully-resolved entry to the UF and holds each entry busy until the UF result for that entry's tag appears on the CDB.

## Interface
Parameters:
- Vj_Vk_sem_valor, 16'b1111_1111_1111_0000: "no value" sentinel for operand fields.
- Qj_Qk_sem_valor, 3'b000: "no producer" tag. Tag 0 is never a valid producer.
- TAG_BASE, 3'b001: tag of entry 0. Entry 1 uses TAG_BASE+1. Must satisfy TAG_BASE ∈ 1..6.

Ports:
- Clock  in  1  sole clock, rising edge.
- Reset  in  1  synchronous, active-high.
- issue_valid  in  1  instruction offered.
- issue_ready  out  1  at least one entry LIVRE.
- issue_op  in  3  UF opcode.
- issue_Vj, issue_Vk  in  16  operand values; meaningful only when the matching Q is 0.
- issue_Qj, issue_Qk  in  3  producer tags; 0 means the V field is valid.
- issue_tag  out  3  tag to be assigned to the offered instruction (lowest-index free entry).
- CDB_valid  in  1  CDB broadcast present.
- Qi_CDB  in  3  broadcasting tag.
- Qi_CDB_data  in  16  broadcast value.
- disp_valid  out  1  a ready entry is offered to the UF.
- disp_ready  in  1  UF accepts.
- disp_op  out  3  opcode of the offered entry.
- disp_Vj, disp_Vk  out  16  resolved operands of the offered entry.
- disp_tag  out  3  tag of the offered entry (the UF broadcasts its result with this tag).

## Operation
- Per-entry state: LIVRE, ESPERA (≥1 operand pending), PRONTA (both operands resolved, not dispatched), EXECUTANDO (dispatched, awaiting own CDB broadcast).
- Issue: on issue_valid && issue_ready, the lowest-index LIVRE entry loads op, V and Q.
  - Operand with Q≠0 stores V = sentinel.
  - Next state is PRONTA if both Q=0 after capture, else ESPERA.
  - Age bit marks this entry younger than the other occupied entry.
- Issue-cycle capture: if CDB_valid && Qi_CDB == issue_Qj (≠0), load Qi_CDB_data into Vj and clear Qj. The same rule applies to Vk/Qk, independently. Both operands may capture from one broadcast.
- Snoop: every cycle, for each ESPERA entry with Qj == Qi_CDB and CDB_valid, Vj ← Qi_CDB_data and Qj ← 0. Vk/Qk are handled identically and independently. ESPERA→PRONTA once both Q are 0 (registered).
- Broadcasts with Qi_CDB = 0 are ignored.
- Dispatch: disp_valid = any PRONTA entry. When both are PRONTA, the older entry wins. On disp_valid && disp_ready the selected entry moves PRONTA→EXECUTANDO.
- Release: EXECUTANDO entry whose own tag appears with CDB_valid → LIVRE. Q fields reset to 0 and V fields to the sentinel.
- A broadcast of an entry's own tag while that entry is not EXECUTANDO does not release it.
- disp_* outputs are don't-care when disp_valid=0; drive them from entry 0.

## Timing
- Reset values:
  - Both entries LIVRE, V = sentinel, Q = 0, age bits 0.
  - issue_ready=1, issue_tag=TAG_BASE.
  - disp_valid=0, disp_op=0, disp_Vj=disp_Vk=sentinel, disp_tag=TAG_BASE.
- Reset mid-operation drops all entries. Pending broadcasts are not retained.
- issue_ready and issue_tag are combinational from registered state only. An entry released in cycle t accepts an issue in t+1, not t.
- Minimum latency, operands ready at issue: issue accepted at edge t; disp_valid=1 in cycle t+1.
- Last operand arriving on the CDB in cycle t: PRONTA after edge t; disp_valid in t+1 (without bypass, see Configuration).
- Dispatch and release of the same entry in one cycle is impossible. Release requires EXECUTANDO at the start of the cycle.
- Simultaneous events in one cycle:
  - Issue, snoop, dispatch of the other entry and release are all legal together.
  - Each entry's next state is evaluated independently.

## Configuration
- ESTACAO_BYPASS_CDB_EN defined:
  - An ESPERA entry whose last pending operand(s) match the current CDB broadcast is dispatchable in the same cycle.
  - disp_Vj/disp_Vk mux in Qi_CDB_data combinationally.
  - A registered PRONTA entry still wins over a bypass candidate regardless of age.
- Undefined: dispatch only from registered PRONTA state (one extra cycle).

## Test plan
- Reset, then issue op=3, Qj=Qk=0, Vj=5, Vk=7 with disp_ready=1 → issue_tag=1; next cycle disp_valid=1, disp_Vj=5, disp_Vk=7, disp_tag=1; issue_ready stays 1.
- Issue with Qj=4, Vk=9; three cycles later CDB (4, 0x0020) → disp_valid rises one cycle after the broadcast (same cycle with ESTACAO_BYPASS_CDB_EN); disp_Vj=0x0020, disp_Vk=9.
- Fill both entries, dispatch entry 0 → issue_ready=0. CDB broadcasts tag 1 → entry 0 LIVRE next cycle; issue_ready=1, issue_tag=1.
- Issue Qj=Qk=5 in the same cycle as CDB (5, 0x1234) → entry PRONTA immediately; dispatched with Vj=Vk=0x1234.
- Entry 1 issued before entry 0 is re-filled; both become PRONTA together → entry 1 dispatched first (disp_tag=2).
- Assert Reset while one entry is EXECUTANDO and one is ESPERA → all outputs at reset values next cycle; a subsequent CDB of the old tags has no effect.
